// File: rtl/atm_pin_entry.sv
// rtl/atm_pin_entry.sv - keypad PIN collector with verdict handshake and lockout
// Optional inactivity timeout enabled by defining KEYPAD_TIMEOUT_EN.
module atm_pin_entry #(
  parameter int MIN_DIGITS     = 4,
  parameter int MAX_DIGITS     = 5,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        card,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        pin_ack,
  input  logic        auth_ok,
  input  logic        auth_fail,
  input  logic        svc_unlock,
  output logic [16:0] pin_value,
  output logic        pin_valid,
  output logic [2:0]  digit_count,
  output logic [2:0]  attempts,
  output logic        entry_err,
  output logic        authed,
  output logic        locked,
  output logic        timeout
);

  typedef enum logic [2:0] {IDLE, ENTRY, PRESENT, WAIT_RES, AUTHED, LOCKED} state_t;

  localparam logic [2:0] MIN_CNT = 3'(MIN_DIGITS);
  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);
  localparam logic [2:0] MAX_ATT = 3'(MAX_ATTEMPTS);

  state_t      state_q, state_d;
  logic [16:0] acc_q, acc_d;
  logic [16:0] pin_q, pin_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  att_q, att_d;
  logic        err_q, err_d;
  logic        tmo_q, tmo_d;
  logic        is_digit;
  logic [2:0]  att_inc;

`ifdef KEYPAD_TIMEOUT_EN
  logic [31:0] tmr_q, tmr_d;
  logic        key_hit;
  assign key_hit = key_valid && (is_digit || key_code == 4'hA || key_code == 4'hE);
`endif

  assign is_digit = key_code <= 4'd9;
  assign att_inc  = att_q + 3'd1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    pin_d   = pin_q;
    cnt_d   = cnt_q;
    att_d   = att_q;
    err_d   = 1'b0;
    tmo_d   = 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
    tmr_d   = 32'd0;
`endif
    case (state_q)
      IDLE: begin
        if (card) begin
          state_d = ENTRY;
          acc_d   = 17'd0;
          cnt_d   = 3'd0;
        end
      end
      ENTRY: begin
        if (key_valid && is_digit) begin
          if (cnt_q < MAX_CNT) begin
            acc_d = (acc_q << 3) + (acc_q << 1) + {13'd0, key_code};
            cnt_d = cnt_q + 3'd1;
          end
        end else if (key_valid && key_code == 4'hA) begin
          acc_d = 17'd0;
          cnt_d = 3'd0;
        end else if (key_valid && key_code == 4'hE) begin
          if (cnt_q >= MIN_CNT) begin
            pin_d   = acc_q;
            state_d = PRESENT;
          end else begin
            err_d = 1'b1;
            acc_d = 17'd0;
            cnt_d = 3'd0;
          end
        end
`ifdef KEYPAD_TIMEOUT_EN
        if (cnt_q != 3'd0 && !key_hit) begin
          if (tmr_q == 32'(TIMEOUT_CYCLES - 1)) begin
            tmo_d = 1'b1;
            acc_d = 17'd0;
            cnt_d = 3'd0;
          end else begin
            tmr_d = tmr_q + 32'd1;
          end
        end
`endif
      end
      PRESENT: begin
        if (pin_ack) begin
          state_d = WAIT_RES;
          acc_d   = 17'd0;
          cnt_d   = 3'd0;
        end
      end
      WAIT_RES: begin
        // A simultaneous ok/fail is treated as a failure.
        if (auth_fail) begin
          att_d   = att_inc;
          state_d = (att_inc == MAX_ATT) ? LOCKED : ENTRY;
        end else if (auth_ok) begin
          att_d   = 3'd0;
          state_d = AUTHED;
        end
      end
      AUTHED: ;
      LOCKED: begin
        if (svc_unlock) begin
          state_d = IDLE;
          att_d   = 3'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Card removal overrides any same-cycle key, ack or verdict.
    if (!card && state_q != IDLE && state_q != LOCKED) begin
      state_d = IDLE;
      acc_d   = 17'd0;
      cnt_d   = 3'd0;
      att_d   = 3'd0;
      err_d   = 1'b0;
      tmo_d   = 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
      tmr_d   = 32'd0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= 17'd0;
      pin_q   <= 17'd0;
      cnt_q   <= 3'd0;
      att_q   <= 3'd0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      pin_q   <= pin_d;
      cnt_q   <= cnt_d;
      att_q   <= att_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef KEYPAD_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) tmr_q <= 32'd0;
    else      tmr_q <= tmr_d;
  end
`endif

  assign pin_value   = pin_q;
  assign pin_valid   = (state_q == PRESENT);
  assign digit_count = cnt_q;
  assign attempts    = att_q;
  assign entry_err   = err_q;
  assign authed      = (state_q == AUTHED);
  assign locked      = (state_q == LOCKED);
  assign timeout     = tmo_q;

endmodule
